// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/flush controller for the pipelined-plus-cache core.
// Drives enables and active-low flushes of the F/D, D/E, E/M and M/W registers.
// Outputs are combinational from the FSM state and the current hazard inputs.
module hazard_ctrl #(
  parameter int                    REG_ADDR_WIDTH = 5,
  parameter int                    SRC_WIDTH      = 2,
  parameter logic [SRC_WIDTH-1:0]  LOAD_SRC       = 2'b01,
  parameter int                    MUL_LATENCY    = 3,
  parameter int                    CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_d,
  input  logic [REG_ADDR_WIDTH-1:0] RS1_d,
  input  logic [REG_ADDR_WIDTH-1:0] RS2_d,
  input  logic                      valid_e,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_e,
  input  logic                      RegWrite_e,
  input  logic [SRC_WIDTH-1:0]      ResultSrc_e,
  input  logic                      mul_sel_e,
  input  logic                      mispredict_e,
  input  logic                      icache_miss,
  input  logic                      dcache_miss,
  input  logic                      dcache_ready,
  output logic                      en_fd,
  output logic                      en_de,
  output logic                      en_em,
  output logic                      en_mw,
  output logic                      flush_fd_n,
  output logic                      flush_de_n,
  output logic                      flush_em_n,
  output logic                      flush_mw_n,
  output logic                      mul_busy,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  typedef enum logic [1:0] {RUN, MUL_WAIT, MEM_WAIT} state_t;

  // Single-cycle multiplies never stall; longer ones preload the down-counter
  // so that it reaches zero on the release cycle.
  localparam bit         MUL_MULTI = (MUL_LATENCY > 1);
  localparam logic [3:0] MUL_INIT  = MUL_MULTI ? 4'(MUL_LATENCY - 2) : 4'd0;

  state_t     state, state_nxt;
  state_t     ret_state, ret_nxt;
  logic [3:0] mul_cnt, mul_cnt_nxt;

  logic mem_hz, mis_hz, mul_new, mul_hz, lu_hz;

  // Hazard detection, before prioritisation
  always_comb begin
    mem_hz  = (state == MEM_WAIT) || dcache_miss;
    mis_hz  = mispredict_e && valid_e;
    mul_new = (state == RUN) && valid_e && mul_sel_e && MUL_MULTI;
    mul_hz  = ((state == MUL_WAIT) && (mul_cnt != 4'd0)) || mul_new;
    lu_hz   = valid_e && valid_d && RegWrite_e && (ResultSrc_e == LOAD_SRC) &&
              (Rd_e != '0) && ((Rd_e == RS1_d) || (Rd_e == RS2_d));
  end

  // Priority encode hazards onto enables/flushes; reset holds everything in flush
  always_comb begin
    en_fd = 1'b1; en_de = 1'b1; en_em = 1'b1; en_mw = 1'b1;
    flush_fd_n = 1'b1; flush_de_n = 1'b1; flush_em_n = 1'b1; flush_mw_n = 1'b1;
    if (!rst_n) begin
      en_fd = 1'b0; en_de = 1'b0; en_em = 1'b0; en_mw = 1'b0;
      flush_fd_n = 1'b0; flush_de_n = 1'b0; flush_em_n = 1'b0; flush_mw_n = 1'b0;
    end else if (mem_hz) begin
      en_fd = 1'b0; en_de = 1'b0; en_em = 1'b0; en_mw = 1'b0;
      flush_mw_n = 1'b0;
    end else if (mis_hz) begin
      flush_fd_n = 1'b0; flush_de_n = 1'b0;
    end else if (mul_hz) begin
      en_fd = 1'b0; en_de = 1'b0; en_em = 1'b0;
      flush_em_n = 1'b0;
    end else if (lu_hz) begin
      en_fd = 1'b0; en_de = 1'b0;
      flush_de_n = 1'b0;
    end else if (icache_miss) begin
      en_fd = 1'b0;
      flush_fd_n = 1'b0;
    end
  end

  assign mul_busy = (state == MUL_WAIT);

  // Next-state logic; the mul leaves E on the release edge, so RUN is safe to re-enter
  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret_state;
    mul_cnt_nxt = mul_cnt;
    unique case (state)
      RUN: begin
        if (dcache_miss) begin
          state_nxt = MEM_WAIT;
          ret_nxt   = RUN;
        end else if (valid_e && mul_sel_e && MUL_MULTI && !mispredict_e) begin
          state_nxt   = MUL_WAIT;
          mul_cnt_nxt = MUL_INIT;
        end
      end
      MUL_WAIT: begin
        if (dcache_miss) begin
          state_nxt = MEM_WAIT;
          ret_nxt   = MUL_WAIT;
        end else if (mul_cnt != 4'd0) begin
          mul_cnt_nxt = mul_cnt - 4'd1;
        end else begin
          state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (dcache_ready) state_nxt = ret_state;
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM state, return state and multiplier down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
      mul_cnt   <= 4'd0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      mul_cnt   <= mul_cnt_nxt;
    end
  end

  // Free-running count of fetch-stalled cycles, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stall_count <= '0;
    else if (!en_fd) stall_count <= stall_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected outputs are queued when stimulus is
// applied and popped/compared on the following falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_d, valid_e, RegWrite_e, mul_sel_e, mispredict_e;
  logic       icache_miss, dcache_miss, dcache_ready;
  logic [4:0] RS1_d, RS2_d, Rd_e;
  logic [1:0] ResultSrc_e;
  logic       en_fd, en_de, en_em, en_mw;
  logic       flush_fd_n, flush_de_n, flush_em_n, flush_mw_n, mul_busy;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [3:0]  en;   // {fd,de,em,mw}
    logic [3:0]  fl;   // {fd,de,em,mw}, active low
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  hazard_ctrl #(
    .REG_ADDR_WIDTH(5), .SRC_WIDTH(2), .LOAD_SRC(2'b01),
    .MUL_LATENCY(3), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_d(valid_d), .RS1_d(RS1_d), .RS2_d(RS2_d),
    .valid_e(valid_e), .Rd_e(Rd_e), .RegWrite_e(RegWrite_e),
    .ResultSrc_e(ResultSrc_e), .mul_sel_e(mul_sel_e),
    .mispredict_e(mispredict_e), .icache_miss(icache_miss),
    .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
    .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .flush_fd_n(flush_fd_n), .flush_de_n(flush_de_n),
    .flush_em_n(flush_em_n), .flush_mw_n(flush_mw_n),
    .mul_busy(mul_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    valid_d = 1'b0; valid_e = 1'b0; RegWrite_e = 1'b0; mul_sel_e = 1'b0;
    mispredict_e = 1'b0; icache_miss = 1'b0; dcache_miss = 1'b0;
    dcache_ready = 1'b0; RS1_d = '0; RS2_d = '0; Rd_e = '0; ResultSrc_e = 2'b00;
  endtask

  task automatic load_in_e(input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2);
    valid_d = 1'b1; valid_e = 1'b1; RegWrite_e = 1'b1; ResultSrc_e = 2'b01;
    Rd_e = rd; RS1_d = rs1; RS2_d = rs2;
  endtask

  task automatic push(input string tag, input logic [3:0] en, input logic [3:0] fl,
                      input logic busy, input logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.en = en; e.fl = fl; e.busy = busy; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    logic [8:0] act, exp;
    e   = sb.pop_front();
    act = {en_fd, en_de, en_em, en_mw, flush_fd_n, flush_de_n, flush_em_n, flush_mw_n, mul_busy};
    exp = {e.en, e.fl, e.busy};
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: en/flush/busy got %b expected %b", e.tag, act, exp);
    end
    checks++;
    assert (stall_count === e.cnt) else begin
      errors++;
      $error("FAIL %s: stall_count got %0d expected %0d", e.tag, stall_count, e.cnt);
    end
  endtask

  // Inputs are already applied; check on the falling edge, then step one cycle.
  task automatic step(input string tag, input logic [3:0] en, input logic [3:0] fl,
                      input logic busy, input logic [31:0] cnt);
    push(tag, en, fl, busy, cnt);
    @(negedge clk);
    compare();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    step("reset", 4'b0000, 4'b0000, 1'b0, 0);
    rst_n = 1'b1;

    step("idle", 4'b1111, 4'b1111, 1'b0, 0);

    // load-use on RS1, then on RS2: one stall cycle each
    load_in_e(5'd5, 5'd5, 5'd7);
    step("lu_rs1", 4'b0011, 4'b1011, 1'b0, 0);
    idle();
    step("lu_rs1_after", 4'b1111, 4'b1111, 1'b0, 1);
    load_in_e(5'd9, 5'd3, 5'd9);
    step("lu_rs2", 4'b0011, 4'b1011, 1'b0, 1);
    idle();
    step("lu_rs2_after", 4'b1111, 4'b1111, 1'b0, 2);
    load_in_e(5'd0, 5'd0, 5'd0);
    step("lu_x0", 4'b1111, 4'b1111, 1'b0, 2);
    load_in_e(5'd5, 5'd5, 5'd5);
    ResultSrc_e = 2'b00;
    step("lu_not_load", 4'b1111, 4'b1111, 1'b0, 2);

    // multiply, latency 3: two stall cycles then release
    idle(); valid_e = 1'b1; mul_sel_e = 1'b1;
    step("mul_c1", 4'b0001, 4'b1101, 1'b0, 2);
    step("mul_c2", 4'b0001, 4'b1101, 1'b1, 3);
    step("mul_rel", 4'b1111, 4'b1111, 1'b1, 4);
    idle();
    step("mul_done", 4'b1111, 4'b1111, 1'b0, 4);

    // mispredict beats load-use
    load_in_e(5'd5, 5'd5, 5'd0); mispredict_e = 1'b1;
    step("mis_lu", 4'b1111, 4'b0011, 1'b0, 4);
    idle();
    step("mis_after", 4'b1111, 4'b1111, 1'b0, 4);

    // dcache miss while MUL_WAIT has mul_cnt = 1
    valid_e = 1'b1; mul_sel_e = 1'b1;
    step("mm_mul", 4'b0001, 4'b1101, 1'b0, 4);
    dcache_miss = 1'b1;
    step("mm_miss", 4'b0000, 4'b1110, 1'b1, 5);
    dcache_miss = 1'b0; mispredict_e = 1'b1;
    step("mm_wait_mis", 4'b0000, 4'b1110, 1'b0, 6);
    mispredict_e = 1'b0; dcache_ready = 1'b1;
    step("mm_ready", 4'b0000, 4'b1110, 1'b0, 7);
    dcache_ready = 1'b0;
    step("mm_mul_rest", 4'b0001, 4'b1101, 1'b1, 8);
    step("mm_rel", 4'b1111, 4'b1111, 1'b1, 9);
    idle();
    step("mm_done", 4'b1111, 4'b1111, 1'b0, 9);

    // stray dcache_ready in RUN does nothing
    dcache_ready = 1'b1;
    step("ready_run", 4'b1111, 4'b1111, 1'b0, 9);
    idle();
    step("ready_run2", 4'b1111, 4'b1111, 1'b0, 9);

    // plain dcache miss from RUN, stall includes the ready cycle
    dcache_miss = 1'b1;
    step("dm_miss", 4'b0000, 4'b1110, 1'b0, 9);
    dcache_miss = 1'b0; dcache_ready = 1'b1;
    step("dm_ready", 4'b0000, 4'b1110, 1'b0, 10);
    idle();
    step("dm_done", 4'b1111, 4'b1111, 1'b0, 11);

    // icache miss held 4 cycles
    icache_miss = 1'b1;
    for (int i = 0; i < 4; i++)
      step("imiss", 4'b0111, 4'b0111, 1'b0, 32'(11 + i));
    idle();
    step("imiss_done", 4'b1111, 4'b1111, 1'b0, 15);

    // asynchronous reset in the middle of MEM_WAIT
    dcache_miss = 1'b1;
    step("rst_miss", 4'b0000, 4'b1110, 1'b0, 15);
    idle();
    step("rst_memwait", 4'b0000, 4'b1110, 1'b0, 16);
    #2 rst_n = 1'b0;
    #1;
    push("async_rst", 4'b0000, 4'b0000, 1'b0, 0);
    compare();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst", 4'b1111, 4'b1111, 1'b0, 0);
    load_in_e(5'd4, 5'd4, 5'd0);
    step("post_rst_lu", 4'b0011, 4'b1011, 1'b0, 0);
    idle();
    step("post_rst_idle", 4'b1111, 4'b1111, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
